// File: rtl/fir_sample_source_if.sv
// fir_sample_source_if: valid/ready sample channel into the FIR X1 input.
// master drives sample/sample_valid, slave drives sample_ready.
interface fir_sample_source_if;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/fir_sample_source.sv
// fir_sample_source: LFSR sample generator with button start/stop for the FIR.
// Ports: CLOCK_50, reset_n (async low), toggleBtn (raw, low = pressed),
//   src (sample/sample_valid out, sample_ready in), enable, restart,
//   sample_count, overrun.
// Macro FIR_SRC_DEBOUNCE_EN: when defined the synchronized button must be
//   stable DEBOUNCE_CYCLES cycles; when undefined an edge of the
//   synchronizer output is a press and DEBOUNCE_CYCLES is ignored.
module fir_sample_source #(
  parameter int          RATE_DIV        = 50_000_000,
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                toggleBtn,
  fir_sample_source_if.master src,
  output logic                enable,
  output logic                restart,
  output logic [15:0]         sample_count,
  output logic                overrun
);

`ifdef FIR_SRC_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  // With the debouncer off the threshold collapses to 0, which makes the
  // debounced level a one-cycle-delayed copy of the synchronizer output.
  localparam int DB_N = DB_EN ? DEBOUNCE_CYCLES : 0;
  localparam int CW   = (DB_N > 0) ? $clog2(DB_N + 1) : 1;
  localparam int DW   = $clog2(RATE_DIV);
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_s1;
  logic            r_s2;
  logic            r_deb;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_div;
  logic [15:0]     r_lfsr;
  logic [7:0]      r_sample;
  logic            r_valid;
  logic            w_press;
  logic            w_start;
  logic            w_stop;
  logic            w_tick;
  logic            w_xfer;
  logic            w_free;
  logic [15:0]     w_lfsr_nx;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= toggleBtn;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= 1'b1;
      r_cnt <= '0;
    end else if (r_s2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DB_N)) begin
      r_deb <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Press is the edge on which the debounced level falls 1->0.
  assign w_press = r_deb & ~r_s2 & (r_cnt == CW'(DB_N));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_stop  = 1'b0;
    unique case (r_state)
      IDLE: if (w_press) begin
        w_next  = RUN;
        w_start = 1'b1;
      end
      RUN: if (w_press) begin
        w_next = IDLE;
        w_stop = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_tick = (r_state == RUN) && (r_div == DW'(RATE_DIV - 1));
  assign w_xfer = r_valid & src.sample_ready;
  assign w_free = ~r_valid | src.sample_ready;
  assign w_lfsr_nx = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr       <= SEED;
      r_div        <= '0;
      r_sample     <= '0;
      r_valid      <= 1'b0;
      sample_count <= '0;
      overrun      <= 1'b0;
      enable       <= 1'b0;
      restart      <= 1'b0;
    end else begin
      restart <= w_start;
      enable  <= (w_next == RUN);
      if (w_start) begin
        r_lfsr       <= SEED;
        r_div        <= '0;
        r_valid      <= 1'b0;
        sample_count <= '0;
        overrun      <= 1'b0;
      end else if (r_state == RUN) begin
        if (w_xfer) sample_count <= sample_count + 16'd1;
        if (w_stop) begin
          r_valid <= 1'b0;
          r_div   <= '0;
        end else begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
          // A tick only loads when the slot is free or drains this edge.
          if (w_tick && w_free) begin
            r_lfsr   <= w_lfsr_nx;
            r_sample <= w_lfsr_nx[7:0];
            r_valid  <= 1'b1;
          end else begin
            if (w_xfer) r_valid <= 1'b0;
            if (w_tick) overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign src.sample       = r_sample;
  assign src.sample_valid = r_valid;

endmodule

// File: tb/tb_fir_sample_source.sv
// tb_fir_sample_source: directed bench with sample scoreboard.
// Covers reset, start, sequence, backpressure, bounce, stop, restart.
module tb_fir_sample_source;
  localparam int RD = 4;
  localparam int DB = 8;
`ifdef FIR_SRC_DEBOUNCE_EN
  localparam int LAT  = 2 + DB;
  localparam int HOLD = 12;
`else
  localparam int LAT  = 2;
  localparam int HOLD = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn = 1'b1;
  logic        enable;
  logic        restart;
  logic        overrun;
  logic [15:0] count;

  fir_sample_source_if u_if();

  fir_sample_source #(
    .RATE_DIV(RD),
    .DEBOUNCE_CYCLES(DB),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(rst_n),
    .toggleBtn(btn),
    .src(u_if),
    .enable(enable),
    .restart(restart),
    .sample_count(count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int xfers = 0;
  logic [7:0] exp_q[$];
  int xt[$];

  int lat, rp, cy_chg, t_en, d0, d1, d2, nx, rp_g;
  logic v_prev, v_chg, r_chg, o_chg;
  logic [15:0] c_chg;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always begin
    @(negedge clk);
    if (rst_n && u_if.sample_valid && u_if.sample_ready) begin
      xfers++;
      xt.push_back(cyc);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("sb_sample", 32'(u_if.sample), 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    logic en0;
    logic vlast;
    en0 = enable;
    vlast = u_if.sample_valid;
    lat = 0;
    rp = 0;
    btn = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (restart) rp++;
      if (lat == 0 && enable !== en0) begin
        lat = k;
        v_prev = vlast;
        v_chg = u_if.sample_valid;
        r_chg = restart;
        o_chg = overrun;
        c_chg = count;
        cy_chg = cyc;
      end
      vlast = u_if.sample_valid;
      if (k == hold) btn = 1'b1;
      if (k >= hold && lat != 0 && k > lat) break;
    end
    btn = 1'b1;
  endtask

  initial begin
    u_if.sample_ready = 1'b0;
    step(3);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_restart", 32'(restart), 0);
    chk("rst_valid", 32'(u_if.sample_valid), 0);
    chk("rst_sample", 32'(u_if.sample), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    step(4);
    chk("idle_enable", 32'(enable), 0);

    u_if.sample_ready = 1'b1;
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h38);
    exp_q.push_back(8'h9C);
    press(HOLD);
    chk("start_lat", lat, LAT + 1);
    chk("start_restart_pulses", rp, 1);
    chk("start_restart_at_edge", 32'(r_chg), 1);
    chk("start_count0", 32'(c_chg), 0);
    chk("start_ovr0", 32'(o_chg), 0);
    t_en = cy_chg;
    for (int i = 0; i < 60 && xfers < 3; i++) step(1);
    u_if.sample_ready = 1'b0;
    chk("seq_xfers", xfers, 3);
    d0 = (xt.size() > 0) ? xt[0] - t_en : -1;
    d1 = (xt.size() > 1) ? xt[1] - xt[0] : -1;
    d2 = (xt.size() > 2) ? xt[2] - xt[1] : -1;
    chk("first_sample_lat", d0, RD);
    chk("seq_gap1", d1, RD);
    chk("seq_gap2", d2, RD);
    step(1);
    chk("seq_count3", 32'(count), 3);
    chk("seq_no_overrun", 32'(overrun), 0);

    step(8);
    press(HOLD);
    chk("stop_lat", lat, LAT + 1);
    chk("stop_valid_before", 32'(v_prev), 1);
    chk("stop_valid_drop", 32'(v_chg), 0);
    chk("stop_count_hold", 32'(c_chg), 3);
    chk("stop_no_restart", rp, 0);
    chk("stop_overrun", 32'(o_chg), 1);
    step(20);

`ifdef FIR_SRC_DEBOUNCE_EN
    rp_g = 0;
    for (int g = 5; g <= 7; g += 2) begin
      btn = 1'b0;
      for (int i = 0; i < g; i++) begin
        step(1);
        if (restart) rp_g++;
      end
      btn = 1'b1;
      for (int i = 0; i < 14; i++) begin
        step(1);
        if (restart) rp_g++;
      end
    end
    chk("glitch_enable", 32'(enable), 0);
    chk("glitch_restart", rp_g, 0);
`endif

    exp_q.push_back(8'h70);
    exp_q.push_back(8'h38);
    press(HOLD);
    chk("restart_lat", lat, LAT + 1);
    chk("restart_pulses", rp, 1);
    chk("restart_count0", 32'(c_chg), 0);
    chk("restart_ovr0", 32'(o_chg), 0);
    for (int i = 0; i < 20 && !u_if.sample_valid; i++) step(1);
    chk("bp_valid", 32'(u_if.sample_valid), 1);
    chk("bp_first", 32'(u_if.sample), 32'h70);
    step(10);
    chk("bp_hold", 32'(u_if.sample), 32'h70);
    chk("bp_valid_hold", 32'(u_if.sample_valid), 1);
    chk("bp_overrun", 32'(overrun), 1);
    nx = xfers;
    u_if.sample_ready = 1'b1;
    for (int i = 0; i < 20 && xfers < nx + 2; i++) step(1);
    u_if.sample_ready = 1'b0;
    chk("bp_xfers", xfers - nx, 2);
    step(1);
    chk("bp_count", 32'(count), 2);
    chk("sb_drained", exp_q.size(), 0);

    #3 rst_n = 1'b0;
    #1;
    chk("arst_enable", 32'(enable), 0);
    chk("arst_restart", 32'(restart), 0);
    chk("arst_valid", 32'(u_if.sample_valid), 0);
    chk("arst_sample", 32'(u_if.sample), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_overrun", 32'(overrun), 0);
    step(3);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_enable", 32'(enable), 0);
    chk("post_rst_valid", 32'(u_if.sample_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fir_sample_source.md
# fir_sample_source

Sample generator feeding the FIR moving-average datapath. Produces a pseudo-random signed 8-bit sample stream from a 16-bit Galois LFSR at a programmable rate. Samples are offered over a valid/ready handshake to the filter's X1 input. Start/stop is driven by the board toggle button, and a one-cycle `restart` pulse tells the filter to clear its delay line.

## Interface
- `RATE_DIV`, 50_000_000: clock cycles per sample tick; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles needed to accept a button level.
- `LFSR_SEED`, 16'hACE1: LFSR load value on every start; 16'h0000 is replaced by 16'h0001.
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `toggleBtn`  in  1  raw pushbutton, active-low, asynchronous to the clock.
- `sample_ready`  in  1  filter accepts the sample this cycle.
- `enable`  out  1  high while in RUN.
- `restart`  out  1  one-cycle pulse on IDLE→RUN.
- `sample`  out  8  signed sample, equal to `lfsr[7:0]`.
- `sample_valid`  out  1  `sample` is offered.
- `sample_count`  out  16  accepted transfers since last start; wraps modulo 2^16.
- `overrun`  out  1  sticky; a tick arrived while the previous sample was still pending.

## Operation
- **Button path:** 2-flop synchronizer, then debouncer. Debounced level resets to 1. A 1→0 transition of the debounced level is one press.
- **FSM:** IDLE, RUN. Reset state is IDLE.
- **IDLE→RUN on a press:**
  - Load LFSR with `LFSR_SEED`.
  - Clear `sample_count`, the divider and `overrun`.
  - Pulse `restart`.
- **RUN→IDLE on a press:**
  - Drop `sample_valid` on the same edge and discard any pending sample.
  - `sample_count` holds its value.
- **Divider (RUN only):** counts 0..RATE_DIV-1. A tick occurs at RATE_DIV-1, then the divider returns to 0.
- **On tick with no pending sample:**
  - LFSR steps: `lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0)`.
  - `sample` takes the new `lfsr[7:0]`.
  - `sample_valid` is set.
- **On tick while valid && !ready:** the tick is dropped, the LFSR does not step, and `overrun` is set.
- **Transfer:** occurs when `sample_valid && sample_ready` on a rising edge.
  - `sample_valid` clears.
  - `sample_count` increments (0xFFFF→0x0000).
- **Handshake rules:** `sample` is stable while valid is high. Valid never drops without a transfer, except on stop or reset.
- **Ready without valid:** ignored.
- **Tick and transfer on the same edge:** the transfer completes, the new sample loads, valid stays high, and there is no overrun.
- **Press and transfer on the same edge (stopping):** the transfer is counted, then the FSM enters IDLE.
- **Press and tick on the same edge (stopping):** the tick is ignored.
- **Reset (any time, including mid-RUN):**
  - All outputs 0.
  - FSM IDLE.
  - LFSR = seed.
  - Divider 0.
  - Synchronizer/debouncer at released level (1).

## Timing
- **Press latency:** toggleBtn low at edge n → debounced edge at n+2+DEBOUNCE_CYCLES. The FSM changes on that same edge.
- **Visibility on start:** `enable` and `restart` are visible in the cycle after the FSM edge. `restart` is high for exactly one cycle.
- **First sample:** RUN entered at edge t → first `sample_valid` high after edge t+RATE_DIV.
- **Steady state:** with `sample_ready` tied high, one transfer every RATE_DIV cycles.
- **Output registers:** all outputs are registered; there is no combinational path from `sample_ready` to any output.

## Configuration
- `FIR_SRC_DEBOUNCE_EN` defined:
  - Debouncer as described.
- `FIR_SRC_DEBOUNCE_EN` undefined:
  - No debouncer; `DEBOUNCE_CYCLES` is ignored.
  - A press is a 1→0 edge of the synchronizer output.
  - Press latency is 2 cycles.

## Test plan
All scenarios use RATE_DIV=4, DEBOUNCE_CYCLES=8, LFSR_SEED=16'hACE1, macro defined unless noted.
- **Reset:** reset_n low mid-RUN → all outputs 0 asynchronously. After release, the FSM is in IDLE with `enable`=0.
- **Start and sequence:**
  - Press held 12 cycles → single `restart` pulse and `enable`=1.
  - With ready tied high, samples are 0x70, 0x38, 0x9C, each exactly 4 cycles apart.
  - `sample_count` reads 3 after the third transfer.
- **Backpressure:**
  - Ready low for 10 cycles after the first valid → `sample` holds at 0x70 and `overrun`=1.
  - After ready rises, the next accepted sample is 0x38 (no skipped LFSR step).
- **Bounce and stop:**
  - Low glitches shorter than 8 cycles → no state change.
  - Clean press while valid=1 and ready=0 → valid drops on the press edge, `enable`=0, count holds.
- **Restart determinism:** stop then start → first sample again 0x70, `sample_count` 0, `overrun` 0.
- **Macro undefined:** a 3-cycle low pulse on `toggleBtn` toggles the FSM 2 cycles after the falling edge.
